// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S transmitter.
package i2s_pkg;

    localparam int SAMPLE_WIDTH_DEF  = 16;
    localparam int SLOT_BITS_DEF     = 32;
    localparam int BCLK_HALF_DIV_DEF = 2;

    // frame_clk leads each slot's MSB by one bit_clk
    function automatic logic frame_clk_window(
        input int cnt,
        input int slot_bits
    );
        return (cnt >= slot_bits - 1) && (cnt <= 2 * slot_bits - 2);
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit clock divider and frame bit counter for the I2S transmitter.
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int SLOT_BITS     = SLOT_BITS_DEF,
    parameter int BCLK_HALF_DIV = BCLK_HALF_DIV_DEF,
    localparam int CW = $clog2(2 * SLOT_BITS),
    localparam int DW = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic          bit_clk,
    output logic          fall_evt,
    output logic [CW-1:0] bit_cnt,
    output logic [CW-1:0] bit_cnt_nxt
);

    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * SLOT_BITS - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          bit_clk_q, bit_clk_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          div_wrap;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        div_wrap  = (div_cnt_q == DIV_LAST);
        div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
        bit_clk_d = div_wrap ? ~bit_clk_q : bit_clk_q;
        fall_evt  = div_wrap && bit_clk_q;
        cnt_inc   = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + 1'b1;
        bit_cnt_d = fall_evt ? cnt_inc : bit_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            bit_clk_q <= 1'b0;
            bit_cnt_q <= CNT_LAST;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_clk_q <= bit_clk_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_clk     = bit_clk_q;
    assign bit_cnt     = bit_cnt_q;
    assign bit_cnt_nxt = cnt_inc;

endmodule

// File: rtl/i2s_tx.sv
// I2S serializer: one-entry sample buffer, stereo shifters, standard framing.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH  = SAMPLE_WIDTH_DEF,
    parameter int SLOT_BITS     = SLOT_BITS_DEF,
    parameter int BCLK_HALF_DIV = BCLK_HALF_DIV_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sample_l,
    input  logic [SAMPLE_WIDTH-1:0] sample_r,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    bit_clk,
    output logic                    frame_clk,
    output logic                    sdata,
    output logic                    frame_tick,
    output logic                    underrun
);

    localparam int W  = SAMPLE_WIDTH;
    localparam int CW = $clog2(2 * SLOT_BITS);

    logic          fall_evt;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] bit_cnt_nxt;

    i2s_bclk_gen #(
        .SLOT_BITS     (SLOT_BITS),
        .BCLK_HALF_DIV (BCLK_HALF_DIV)
    ) u_bclk (
        .clk         (clk),
        .reset       (reset),
        .bit_clk     (bit_clk),
        .fall_evt    (fall_evt),
        .bit_cnt     (bit_cnt),
        .bit_cnt_nxt (bit_cnt_nxt)
    );

    logic         buf_full_q, buf_full_d;
    logic [W-1:0] buf_l_q, buf_l_d;
    logic [W-1:0] buf_r_q, buf_r_d;
    logic [W-1:0] shift_l_q, shift_l_d;
    logic [W-1:0] shift_r_q, shift_r_d;
    logic         frame_clk_q, frame_clk_d;
    logic         sdata_q, sdata_d;
    logic         frame_tick_q, frame_tick_d;
    logic         underrun_q, underrun_d;

    logic         accept;
    logic         frame_load;
    logic [W-1:0] l_cur;
    logic [W-1:0] r_cur;
    int           cnt;

    always_comb begin
        buf_full_d   = buf_full_q;
        buf_l_d      = buf_l_q;
        buf_r_d      = buf_r_q;
        shift_l_d    = shift_l_q;
        shift_r_d    = shift_r_q;
        frame_clk_d  = frame_clk_q;
        sdata_d      = sdata_q;
        frame_tick_d = 1'b0;
        underrun_d   = 1'b0;
        l_cur        = shift_l_q;
        r_cur        = shift_r_q;
        cnt          = 32'(bit_cnt_nxt);

        accept     = sample_valid && !buf_full_q;
        frame_load = fall_evt && (bit_cnt_nxt == '0);

        if (accept) begin
            buf_full_d = 1'b1;
            buf_l_d    = sample_l;
            buf_r_d    = sample_r;
        end

        // No bypass: a pair accepted this cycle waits for the next frame
        if (frame_load) begin
            frame_tick_d = 1'b1;
            underrun_d   = !buf_full_q;
            if (buf_full_q) begin
                buf_full_d = 1'b0;
                l_cur      = buf_l_q;
                r_cur      = buf_r_q;
            end else begin
                l_cur = '0;
                r_cur = '0;
            end
        end

        if (fall_evt) begin
            frame_clk_d = frame_clk_window(cnt, SLOT_BITS);
            sdata_d     = 1'b0;
            shift_l_d   = l_cur;
            shift_r_d   = r_cur;
            if (cnt < W) begin
                sdata_d   = l_cur[W-1];
                shift_l_d = l_cur << 1;
            end else if (cnt >= SLOT_BITS && cnt < SLOT_BITS + W) begin
                sdata_d   = r_cur[W-1];
                shift_r_d = r_cur << 1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_full_q   <= 1'b0;
            buf_l_q      <= '0;
            buf_r_q      <= '0;
            shift_l_q    <= '0;
            shift_r_q    <= '0;
            frame_clk_q  <= 1'b0;
            sdata_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            buf_full_q   <= buf_full_d;
            buf_l_q      <= buf_l_d;
            buf_r_q      <= buf_r_d;
            shift_l_q    <= shift_l_d;
            shift_r_q    <= shift_r_d;
            frame_clk_q  <= frame_clk_d;
            sdata_q      <= sdata_d;
            frame_tick_q <= frame_tick_d;
            underrun_q   <= underrun_d;
        end
    end

    assign sample_ready = !buf_full_q;
    assign frame_clk    = frame_clk_q;
    assign sdata        = sdata_q;
    assign frame_tick   = frame_tick_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: default build plus a 24-bit, clk/2 build.
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sl = '0;
  logic [15:0] sr = '0;
  logic        sv = 1'b0;
  logic        rdy, bclk, fclk, sd, tick, und;

  logic        rst2 = 1'b1;
  logic [23:0] sl2 = '0;
  logic [23:0] sr2 = '0;
  logic        sv2 = 1'b0;
  logic        rdy2, bclk2, fclk2, sd2, tick2, und2;

  int checks = 0;
  int errors = 0;
  int cyc, cyc2;
  int acc_cnt, tick_cnt, und_cnt;
  int tick_last, tick_period;
  logic [63:0] cap_sd, cap_fc;

  always #5 clk = ~clk;

  i2s_tx dut (
    .clk          (clk),
    .reset        (rst),
    .sample_l     (sl),
    .sample_r     (sr),
    .sample_valid (sv),
    .sample_ready (rdy),
    .bit_clk      (bclk),
    .frame_clk    (fclk),
    .sdata        (sd),
    .frame_tick   (tick),
    .underrun     (und)
  );

  i2s_tx #(
    .SAMPLE_WIDTH  (24),
    .SLOT_BITS     (32),
    .BCLK_HALF_DIV (1)
  ) dut2 (
    .clk          (clk),
    .reset        (rst2),
    .sample_l     (sl2),
    .sample_r     (sr2),
    .sample_valid (sv2),
    .sample_ready (rdy2),
    .bit_clk      (bclk2),
    .frame_clk    (fclk2),
    .sdata        (sd2),
    .frame_tick   (tick2),
    .underrun     (und2)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc         <= 0;
      acc_cnt     <= 0;
      tick_cnt    <= 0;
      und_cnt     <= 0;
      tick_last   <= 0;
      tick_period <= 0;
    end else begin
      cyc <= cyc + 1;
      if (sv && rdy) acc_cnt <= acc_cnt + 1;
      if (und) und_cnt <= und_cnt + 1;
      if (tick) begin
        tick_cnt    <= tick_cnt + 1;
        tick_period <= cyc - tick_last;
        tick_last   <= cyc;
      end
    end
  end

  always @(posedge clk or posedge rst2) begin
    if (rst2) cyc2 <= 0;
    else cyc2 <= cyc2 + 1;
  end

  task automatic chk(input string tag, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc2(input int t);
    while (cyc2 < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cap_frame(input int start);
    for (int n = 0; n < 64; n++) begin
      wait_cyc(start + 4 * n);
      cap_sd[63-n] = sd;
      cap_fc[63-n] = fclk;
    end
  endtask

  task automatic cap_frame2(input int start);
    for (int n = 0; n < 64; n++) begin
      wait_cyc2(start + 2 * n);
      cap_sd[63-n] = sd2;
      cap_fc[63-n] = fclk2;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_bclk", bclk === 1'b0);
    chk("rst_fclk", fclk === 1'b0);
    chk("rst_sdata", sd === 1'b0);
    chk("rst_ready", rdy === 1'b1);
    chk("rst_tick", tick === 1'b0);
    chk("rst_und", und === 1'b0);
    chk("rst2_ready", rdy2 === 1'b1);
    chk("rst2_sdata", sd2 === 1'b0);

    @(negedge clk);
    rst = 1'b0;
    wait_cyc(2);
    chk("idle_bclk_rise", bclk === 1'b1);
    wait_cyc(3);
    chk("idle_tick_c3", tick === 1'b0);
    wait_cyc(4);
    chk("idle_bclk_fall", bclk === 1'b0);
    chk("idle_tick", tick === 1'b1);
    chk("idle_und", und === 1'b1);
    cap_frame(4);
    chk("idle_sdata", cap_sd === 64'h0);
    chk("idle_fclk",
        cap_fc === 64'h0000_0001_FFFF_FFFE);
    wait_cyc(5);
    chk("idle_tick_end", tick === 1'b0);

    sl = 16'hA5C3;
    sr = 16'h8001;
    sv = 1'b1;
    do_reset();
    wait_cyc(1);
    chk("pair_ready_drop", rdy === 1'b0);
    sv = 1'b0;
    wait_cyc(4);
    chk("pair_tick", tick === 1'b1);
    chk("pair_und", und === 1'b0);
    chk("pair_ready_back", rdy === 1'b1);
    chk("pair_msb", sd === 1'b1);
    cap_frame(4);
    chk("pair_sdata",
        cap_sd === 64'hA5C3_0000_8001_0000);
    chk("pair_fclk",
        cap_fc === 64'h0000_0001_FFFF_FFFE);
    wait_cyc(260);
    chk("pair_next_und", und === 1'b1);

    sv = 1'b1;
    do_reset();
    wait_cyc(772);
    chk("b2b_tick", tick === 1'b1);
    chk("b2b_accepts", acc_cnt === 4);
    chk("b2b_ticks", tick_cnt === 3);
    chk("b2b_und", und_cnt === 0);
    chk("b2b_period", tick_period === 256);
    sv = 1'b0;

    do_reset();
    wait_cyc(3);
    sl = 16'h1234;
    sr = 16'hFEDC;
    sv = 1'b1;
    wait_cyc(4);
    sv = 1'b0;
    chk("late_und", und === 1'b1);
    chk("late_ready", rdy === 1'b0);
    cap_frame(4);
    chk("late_zero_frame", cap_sd === 64'h0);
    wait_cyc(260);
    chk("late_next_tick", tick === 1'b1);
    chk("late_next_und", und === 1'b0);
    cap_frame(260);
    chk("late_sdata",
        cap_sd === 64'h1234_0000_FEDC_0000);

    sl = 16'hFFFF;
    sr = 16'hFFFF;
    sv = 1'b1;
    do_reset();
    wait_cyc(86);
    chk("mid_bclk_hi", bclk === 1'b1);
    chk("mid_ready_full", rdy === 1'b0);
    rst = 1'b1;
    sv = 1'b0;
    #1;
    chk("mid_bclk", bclk === 1'b0);
    chk("mid_fclk", fclk === 1'b0);
    chk("mid_sdata", sd === 1'b0);
    chk("mid_ready", rdy === 1'b1);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(4);
    chk("mid_after_und", und === 1'b1);
    cap_frame(4);
    chk("mid_after_frame", cap_sd === 64'h0);

    sl2 = 24'hABCDEF;
    sr2 = 24'h800001;
    sv2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    wait_cyc2(1);
    chk("w24_bclk_rise", bclk2 === 1'b1);
    chk("w24_ready_drop", rdy2 === 1'b0);
    sv2 = 1'b0;
    wait_cyc2(2);
    chk("w24_bclk_fall", bclk2 === 1'b0);
    chk("w24_tick", tick2 === 1'b1);
    chk("w24_und", und2 === 1'b0);
    cap_frame2(2);
    chk("w24_sdata",
        cap_sd === 64'hABCDEF00_80000100);
    chk("w24_fclk",
        cap_fc === 64'h0000_0001_FFFF_FFFE);
    wait_cyc2(129);
    chk("w24_tick_c129", tick2 === 1'b0);
    wait_cyc2(130);
    chk("w24_tick_c130", tick2 === 1'b1);
    chk("w24_und_c130", und2 === 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
